// File: rtl/adder_result_checker.sv
// Compares DUV and reference adder results per vector, counts mismatches and captures the first.
// Optional: ADDER_CHK_STOP_ON_ERR_EN ends the run at the first retiring mismatch.
module adder_result_checker #(
  parameter int N           = 128,
  parameter int TYPE        = 1,
  parameter int NUM_VECTORS = 30000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             cin,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     s_ref,
  input  logic [N-1:0]     s_duv,
  input  logic             cout_ref,
  input  logic             cout_duv,
  input  logic             prop_ref,
  input  logic             prop_duv,
  input  logic             gen_ref,
  input  logic             gen_duv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [N-1:0]     first_err_a,
  output logic [N-1:0]     first_err_b,
  output logic             first_err_cin
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic             CHK_PG = (TYPE != 0);

  state_t state, state_nxt;

  logic             s1_valid;
  logic             s1_mism;
  logic [CNT_W-1:0] s1_idx;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic             s1_cin;

  logic accept;
  logic start_ok;
  logic last_acc;
  logic retire;
  logic stop_err;
  logic mism_sum;
  logic mism_pg;
  logic mism;

  assign accept   = (state == RUN) && sample_valid;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign last_acc = accept && (vec_count == LAST);
  assign retire   = s1_valid && s1_mism;

`ifdef ADDER_CHK_STOP_ON_ERR_EN
  assign stop_err = retire;
`else
  assign stop_err = 1'b0;
`endif

  // Case inequality: an X/Z on either side is flagged rather than hidden.
  assign mism_sum = (s_ref !== s_duv) | (cout_ref !== cout_duv);
  assign mism_pg  = (prop_ref !== prop_duv) | (gen_ref !== gen_duv);
  assign mism     = mism_sum | (CHK_PG & mism_pg);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_acc || stop_err) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
    pass = done && (err_count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_mism         <= 1'b0;
      s1_idx          <= '0;
      s1_a            <= '0;
      s1_b            <= '0;
      s1_cin          <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
    end else if (start_ok) begin
      s1_valid        <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_cin   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_mism   <= mism;
        s1_idx    <= vec_count;
        s1_a      <= a;
        s1_b      <= b;
        s1_cin    <= cin;
        vec_count <= vec_count + CNT_W'(1);
      end
      if (retire) begin
        if (err_count != SAT) err_count <= err_count + CNT_W'(1);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= s1_idx;
          first_err_a     <= s1_a;
          first_err_b     <= s1_b;
          first_err_cin   <= s1_cin;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench: expected run results are queued, a monitor checks them when done rises.
// Two instances share stimulus: TYPE=1 (u1) and TYPE=0 (u0).
module tb_adder_result_checker;

  localparam int N  = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sample_valid = 1'b0;
  logic cin = 1'b0;
  logic [N-1:0] a = '0, b = '0, s_ref = '0, s_duv = '0;
  logic cout_ref = 1'b0, cout_duv = 1'b0;
  logic prop_ref = 1'b0, prop_duv = 1'b0;
  logic gen_ref = 1'b0, gen_duv = 1'b0;

  logic busy1, done1, pass1, fev1, fcin1;
  logic [CW-1:0] vc1, ec1, fidx1;
  logic [N-1:0] fa1, fb1;
  logic busy0, done0, pass0, fev0, fcin0;
  logic [CW-1:0] vc0, ec0, fidx0;
  logic [N-1:0] fa0, fb0;

  always #5 clk = ~clk;

  adder_result_checker #(.N(N), .TYPE(1), .NUM_VECTORS(4), .CNT_W(CW)) u1 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .cin(cin), .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv),
    .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .prop_duv(prop_duv),
    .gen_ref(gen_ref), .gen_duv(gen_duv),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vc1), .err_count(ec1),
    .first_err_valid(fev1), .first_err_idx(fidx1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_cin(fcin1)
  );

  adder_result_checker #(.N(N), .TYPE(0), .NUM_VECTORS(4), .CNT_W(CW)) u0 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .cin(cin), .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv),
    .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .prop_duv(prop_duv),
    .gen_ref(gen_ref), .gen_duv(gen_duv),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vc0), .err_count(ec0),
    .first_err_valid(fev0), .first_err_idx(fidx0),
    .first_err_a(fa0), .first_err_b(fb0), .first_err_cin(fcin0)
  );

`ifdef ADDER_CHK_STOP_ON_ERR_EN
  logic start2 = 1'b0;
  logic busy2, done2, pass2, fev2, fcin2;
  logic [CW-1:0] vc2, ec2, fidx2;
  logic [N-1:0] fa2, fb2;

  adder_result_checker #(.N(N), .TYPE(1), .NUM_VECTORS(10), .CNT_W(CW)) u2 (
    .clk(clk), .rst(rst), .start(start2), .sample_valid(sample_valid),
    .cin(cin), .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv),
    .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .prop_duv(prop_duv),
    .gen_ref(gen_ref), .gen_duv(gen_duv),
    .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vc2), .err_count(ec2),
    .first_err_valid(fev2), .first_err_idx(fidx2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_cin(fcin2)
  );
`endif

  typedef struct {
    int       vc;
    int       ec;
    bit       fev;
    int       idx;
    bit [7:0] fa;
    bit [7:0] fb;
    bit       fcin;
    bit       pass;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t mk(input int vc, input int ec, input bit fev,
                              input int idx, input bit [7:0] fa,
                              input bit [7:0] fb, input bit fcin,
                              input bit ps);
    exp_t e;
    e.vc = vc; e.ec = ec; e.fev = fev; e.idx = idx;
    e.fa = fa; e.fb = fb; e.fcin = fcin; e.pass = ps;
    return e;
  endfunction

  // Monitor: one popped expectation per rising edge of done.
  logic d1_q = 1'b0;
  logic d0_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !d1_q) begin
      if (q1.size() == 0) chk("sb1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_vec_count", vc1, e.vc);
        chk("u1_err_count", ec1, e.ec);
        chk("u1_first_err_valid", {31'b0, fev1}, {31'b0, e.fev});
        chk("u1_first_err_idx", fidx1, e.idx);
        chk("u1_first_err_a", {24'b0, fa1}, {24'b0, e.fa});
        chk("u1_first_err_b", {24'b0, fb1}, {24'b0, e.fb});
        chk("u1_first_err_cin", {31'b0, fcin1}, {31'b0, e.fcin});
        chk("u1_pass", {31'b0, pass1}, {31'b0, e.pass});
      end
    end
    if (done0 && !d0_q) begin
      if (q0.size() == 0) chk("sb0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0_vec_count", vc0, e.vc);
        chk("u0_err_count", ec0, e.ec);
        chk("u0_first_err_valid", {31'b0, fev0}, {31'b0, e.fev});
        chk("u0_first_err_idx", fidx0, e.idx);
        chk("u0_pass", {31'b0, pass0}, {31'b0, e.pass});
      end
    end
    d1_q = done1;
    d0_q = done0;
  end

  // One accepted cycle; sflip corrupts sum bit 0, pflip corrupts prop.
  task automatic vec(input logic [7:0] va, input logic [7:0] vb,
                     input logic vcin, input logic sflip,
                     input logic pflip);
    logic [8:0] sum;
    sum = {1'b0, va} + {1'b0, vb} + {8'b0, vcin};
    a = va; b = vb; cin = vcin;
    s_ref = sum[7:0];
    s_duv = sum[7:0] ^ {7'b0, sflip};
    cout_ref = sum[8]; cout_duv = sum[8];
    prop_ref = &(va ^ vb); prop_duv = &(va ^ vb) ^ pflip;
    gen_ref = sum[8]; gen_duv = sum[8];
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    sample_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_budget", {31'b0, done1}, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy1}, 0);
    chk("rst_done", {31'b0, done1}, 0);
    chk("rst_pass", {31'b0, pass1}, 0);
    chk("rst_vec_count", vc1, 0);
    chk("rst_err_count", ec1, 0);
    chk("rst_fev", {31'b0, fev1}, 0);

    // Reset in the middle of a run with errors already counted.
    pulse_start();
    for (int i = 0; i < 3; i++) vec(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    chk("pre_rst_err_count", ec1, 3);
    sample_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy1}, 0);
    chk("midrst_vec_count", vc1, 0);
    chk("midrst_err_count", ec1, 0);
    chk("midrst_fev", {31'b0, fev1}, 0);
    chk("midrst_fidx", fidx1, 0);
    vec(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    vec(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("idle_ignores_valid", vc1, 0);

    // All matching; done one edge after the DRAIN edge.
    q1.push_back(mk(4, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    q0.push_back(mk(4, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    pulse_start();
    chk("run_busy", {31'b0, busy1}, 1);
    for (int i = 0; i < 4; i++) vec(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    chk("drain_not_done", {31'b0, done1}, 0);
    chk("drain_busy", {31'b0, busy1}, 1);
    idle_cycle();
    chk("done_timing", {31'b0, done1}, 1);
    chk("done_not_busy", {31'b0, busy1}, 0);
    idle_cycle();

    // Sum mismatch on index 2.
    q1.push_back(mk(4, 1, 1, 2, 8'hFF, 8'h01, 1, 0));
    q0.push_back(mk(4, 1, 1, 2, 8'hFF, 8'h01, 1, 0));
    pulse_start();
    chk("restart_clears_vec", vc1, 0);
    vec(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    vec(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    vec(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
    vec(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
    wait_done(5);
    idle_cycle();

    // Propagate mismatch on every vector: only TYPE=1 flags it.
    q1.push_back(mk(4, 4, 1, 0, 8'h10, 8'h20, 0, 0));
    q0.push_back(mk(4, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    pulse_start();
    for (int i = 0; i < 4; i++) vec(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    wait_done(5);
    idle_cycle();

    // Gapped valid 1,0,0,1,1,0,1 with a start ignored mid-run.
    q1.push_back(mk(4, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    q0.push_back(mk(4, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    pulse_start();
    vec(8'h07, 8'h09, 1'b0, 1'b0, 1'b0);
    pulse_start();
    chk("start_in_run_ignored", vc1, 1);
    idle_cycle();
    vec(8'h07, 8'h09, 1'b0, 1'b0, 1'b0);
    vec(8'h07, 8'h09, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    vec(8'h07, 8'h09, 1'b0, 1'b0, 1'b0);
    chk("gap_not_done", {31'b0, done1}, 0);
    chk("gap_vec_count", vc1, 4);
    idle_cycle();
    chk("gap_done_timing", {31'b0, done1}, 1);
    idle_cycle();

`ifdef ADDER_CHK_STOP_ON_ERR_EN
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 10; i++)
      vec(8'h21, 8'h42, 1'b0, (i == 3), 1'b0);
    chk("stop_done", {31'b0, done2}, 1);
    chk("stop_pass", {31'b0, pass2}, 0);
    chk("stop_vec_count", vc2, 5);
    chk("stop_err_count", ec2, 1);
    chk("stop_fidx", fidx2, 3);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("stop_rerun_vec", vc2, 0);
    chk("stop_rerun_err", ec2, 0);
    chk("stop_rerun_fev", {31'b0, fev2}, 0);
    chk("stop_rerun_busy", {31'b0, busy2}, 1);
    for (int i = 0; i < 10; i++) vec(8'h21, 8'h42, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    chk("stop_rerun_pass", {31'b0, pass2}, 1);
    chk("stop_rerun_count", vc2, 10);
`endif

    repeat (3) idle_cycle();
    chk("sb1_drained", q1.size(), 0);
    chk("sb0_drained", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
